// File: rtl/lcd_seq_controller.sv
// HD44780-class character LCD sequencer: runs the init command list after reset
// or on request, then drains {RS, byte} entries from a show-ahead buffer as
// 8-bit beats or high/low nibble beats, each beat paced by the timing driver.
module lcd_seq_controller #(
  parameter int unsigned BUS_WIDTH   = 4,
  parameter int unsigned NUM_LINES   = 2,
  parameter int unsigned FONT_5X10   = 0,
  parameter int unsigned CURSOR_ON   = 0,
  parameter int unsigned BLINK_ON    = 0,
  parameter int unsigned ENTRY_SHIFT = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_reinit,
  input  logic                 i_buf_has_entry,
  input  logic [8:0]           i_buf_data,
  output logic                 o_buf_rd_en,
  input  logic                 i_is_ready,
  output logic [BUS_WIDTH-1:0] o_display_data,
  output logic                 o_display_data_valid,
  output logic                 o_RS,
  output logic                 o_long_exec,
  output logic                 o_init_done,
  output logic                 o_busy
);

  localparam int unsigned IDX_W = 4;
  localparam logic IS_8BIT = (BUS_WIDTH == 8);

  // Init beat index of the last beat, and of the first beat of the clear command
  localparam logic [IDX_W-1:0] LAST_IDX = IS_8BIT ? IDX_W'(3) : IDX_W'(8);
  localparam logic [IDX_W-1:0] CLR_IDX  = IS_8BIT ? IDX_W'(3) : IDX_W'(7);

  localparam logic [7:0] FS_BYTE  = {3'b001, IS_8BIT, (NUM_LINES == 2), (FONT_5X10 != 0), 2'b00};
  localparam logic [7:0] DC_BYTE  = {5'b00001, 1'b1, (CURSOR_ON != 0), (BLINK_ON != 0)};
  localparam logic [7:0] EM_BYTE  = {6'b000001, 1'b1, (ENTRY_SHIFT != 0)};
  localparam logic [7:0] CLR_BYTE = 8'h01;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_SEND_HI = 2'd2,
    ST_SEND_LO = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   pend_q, pend_d;
  logic                   done_q, done_d;
  logic [7:0]             byte_q, byte_d;
  logic                   rs_q, rs_d;
  logic                   rd_en_q, rd_en_d;
  logic                   valid_q, valid_d;
  logic [BUS_WIDTH-1:0]   data_q, data_d;
  logic                   out_rs_q, out_rs_d;
  logic                   long_q, long_d;
  logic                   busy_q, busy_d;
  logic                   xfer;
  logic [7:0]             beat;

  // Payload of init beat idx; 4-bit mode leads with the lone 4'b0010 nibble
  function automatic logic [7:0] init_beat(input logic [IDX_W-1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    if (IS_8BIT) begin
      case (idx)
        4'd0:    b = FS_BYTE;
        4'd1:    b = DC_BYTE;
        4'd2:    b = EM_BYTE;
        default: b = CLR_BYTE;
      endcase
    end else begin
      case (idx)
        4'd0:    b = 8'h02;
        4'd1:    b = {4'h0, FS_BYTE[7:4]};
        4'd2:    b = {4'h0, FS_BYTE[3:0]};
        4'd3:    b = {4'h0, DC_BYTE[7:4]};
        4'd4:    b = {4'h0, DC_BYTE[3:0]};
        4'd5:    b = {4'h0, EM_BYTE[7:4]};
        4'd6:    b = {4'h0, EM_BYTE[3:0]};
        4'd7:    b = {4'h0, CLR_BYTE[7:4]};
        default: b = {4'h0, CLR_BYTE[3:0]};
      endcase
    end
    return b;
  endfunction

  // Next state, then the registered beat/strobe outputs derived from it
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pend_d   = pend_q | i_reinit;
    done_d   = done_q;
    byte_d   = byte_q;
    rs_d     = rs_q;
    xfer     = valid_q & i_is_ready;
    valid_d  = 1'b0;
    beat     = 8'h00;
    out_rs_d = 1'b0;
    long_d   = 1'b0;

    case (state_q)
      ST_INIT: begin
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_IDLE: begin
        // A committed pop always completes; otherwise a pending reinit wins
        if (rd_en_q) begin
          byte_d  = i_buf_data[7:0];
          rs_d    = i_buf_data[8];
          state_d = ST_SEND_HI;
        end else if (pend_q) begin
          pend_d  = i_reinit;
          done_d  = 1'b0;
          idx_d   = '0;
          state_d = ST_INIT;
        end
      end
      ST_SEND_HI: begin
        if (xfer) state_d = IS_8BIT ? ST_IDLE : ST_SEND_LO;
      end
      ST_SEND_LO: begin
        if (xfer) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase

    // Pop is decided one cycle ahead so the strobe coincides with the latch cycle
    rd_en_d = (state_d == ST_IDLE) && done_d && i_buf_has_entry && !pend_d && !rd_en_q;
    busy_d  = (state_d != ST_IDLE);

    case (state_d)
      ST_INIT: begin
        valid_d = 1'b1;
        beat    = init_beat(idx_d);
        long_d  = (idx_d >= CLR_IDX);
      end
      ST_SEND_HI: begin
        valid_d  = 1'b1;
        beat     = IS_8BIT ? byte_d : {4'h0, byte_d[7:4]};
        out_rs_d = rs_d;
        long_d   = !rs_d && (byte_d == 8'h01 || byte_d == 8'h02 || byte_d == 8'h03);
      end
      ST_SEND_LO: begin
        valid_d  = 1'b1;
        beat     = {4'h0, byte_d[3:0]};
        out_rs_d = rs_d;
        long_d   = !rs_d && (byte_d == 8'h01 || byte_d == 8'h02 || byte_d == 8'h03);
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
    data_d = BUS_WIDTH'(beat);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_INIT;
      idx_q    <= '0;
      pend_q   <= 1'b0;
      done_q   <= 1'b0;
      byte_q   <= 8'h00;
      rs_q     <= 1'b0;
      rd_en_q  <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      out_rs_q <= 1'b0;
      long_q   <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      done_q   <= done_d;
      byte_q   <= byte_d;
      rs_q     <= rs_d;
      rd_en_q  <= rd_en_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      out_rs_q <= out_rs_d;
      long_q   <= long_d;
      busy_q   <= busy_d;
    end
  end

  assign o_buf_rd_en          = rd_en_q;
  assign o_display_data       = data_q;
  assign o_display_data_valid = valid_q;
  assign o_RS                 = out_rs_q;
  assign o_long_exec          = long_q;
  assign o_init_done          = done_q;
  assign o_busy               = busy_q;

endmodule

// File: doc/lcd_seq_controller.md
Name: lcd_seq_controller

Overview:
- Parametrised successor to the current LCD display controller: HD44780-class character LCD sequencer supporting 4-bit or 8-bit bus modes.
- After reset, or on request, it issues a configurable init command sequence. It then drains {RS, byte} entries from a show-ahead buffer, splitting each byte into nibbles in 4-bit mode.
- Sits between the display entry buffer and the LCD bus timing driver. The timing driver paces every beat via i_is_ready.

Parameters:
- BUS_WIDTH, 4, LCD data bus width; legal values 4 or 8.
- NUM_LINES, 2, display lines; 1 or 2 (function set N bit).
- FONT_5X10, 0, 1 selects 5x10 font (function set F bit).
- CURSOR_ON, 0, display control C bit.
- BLINK_ON, 0, display control B bit.
- ENTRY_SHIFT, 0, entry mode S bit. I/D is always 1.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_reinit  in  1  single-cycle request to rerun the init sequence
- i_buf_has_entry  in  1  buffer non-empty; i_buf_data is valid
- i_buf_data  in  9  {RS, byte} at buffer head (show-ahead)
- o_buf_rd_en  out  1  pop strobe, one cycle per entry
- i_is_ready  in  1  timing driver can accept a beat this cycle
- o_display_data  out  BUS_WIDTH  beat payload
- o_display_data_valid  out  1  beat valid
- o_RS  out  1  register select for the current beat
- o_long_exec  out  1  current beat belongs to a clear (0x01) or home (0x02/0x03) command with RS=0
- o_init_done  out  1  init sequence complete
- o_busy  out  1  not in IDLE

Behaviour:
- Reset: i_clk and i_rst only; i_rst is synchronous and active-high. On reset, state enters INIT, the init index is cleared, and the pending reinit flag is cleared.
- Output reset values: o_buf_rd_en=0, o_display_data_valid=0, o_display_data=0, o_RS=0, o_long_exec=0, o_init_done=0. o_busy=1 from the first cycle after reset.
- Beat transfer:
  - A beat transfers in any cycle where o_display_data_valid=1 and i_is_ready=1.
  - o_display_data_valid, o_display_data and o_RS depend only on registered state, never combinationally on i_is_ready.
  - Payload is held stable until the beat transfers.
- Init command list, all RS=0:
  - FS byte = {3'b001, DL, N, F, 2'b00}, with DL = (BUS_WIDTH==8), N = (NUM_LINES==2), F = FONT_5X10.
  - Order: FS, DC = {5'b00001, 1, CURSOR_ON, BLINK_ON}, EM = {6'b000001, 1, ENTRY_SHIFT}, CLR = 8'h01.
  - 4-bit mode prepends one single-nibble beat 4'b0010 before FS. Every byte is then sent high nibble first, then low nibble.
  - 8-bit mode sends each byte as one beat.
- Beat counts:
  - Defaults (BUS_WIDTH=4) give 9 beats: 2,2,8,0,C,0,6,0,1.
  - BUS_WIDTH=8 gives 4 beats: 0x38,0x0C,0x06,0x01.
- States: INIT, IDLE, SEND_HI, SEND_LO. In 8-bit mode only SEND_HI is used, carrying the full byte.
  - INIT: step the init index on each transferred beat. After the last beat transfers: o_init_done<=1, go to IDLE.
  - IDLE: valid=0. If a reinit is pending, clear o_init_done, clear the index and go to INIT. Otherwise, if i_buf_has_entry and o_init_done: assert o_buf_rd_en for exactly that cycle, latch i_buf_data, go to SEND_HI next cycle. Reinit has priority over a buffer entry.
  - SEND_HI: drive byte[7:4] (or byte[7:0] in 8-bit mode) with the latched RS. On transfer, go to SEND_LO (4-bit) or IDLE (8-bit).
  - SEND_LO: drive byte[3:0]. On transfer, go to IDLE.
- Latency: rd_en in cycle N gives valid in N+1. Back-to-back entries therefore cost at least 3 cycles (4-bit) or 2 cycles (8-bit) each with i_is_ready held at 1.
- i_reinit handling: a pulse in any state sets the pending flag. The flag is consumed only in IDLE, so an in-flight entry always completes both nibbles. A pulse during INIT is also deferred: the current init finishes, then init reruns.
- o_long_exec: high on every beat of CLR during init, and on beats of entries with RS=0 and byte in {0x01,0x02,0x03}.
- Buffer gating: no pop occurs while o_init_done=0, even if i_buf_has_entry=1.
- Reset mid-beat: the beat is abandoned, and the sequence restarts from the preamble nibble after reset.

Test Plan:
- Defaults, i_is_ready tied 1 → beats 2,2,8,0,C,0,6,0,1 on consecutive cycles, all RS=0; o_long_exec high on the last two; o_init_done rises on the cycle after the final beat.
- i_is_ready toggling 1-of-4 cycles during init → each payload held unchanged until transfer; same 9 beats, none duplicated or skipped.
- After init, buffer entry {1,0x41} → rd_en one cycle, then beats 4 then 1 with RS=1; o_long_exec=0; o_busy returns to 0.
- BUS_WIDTH=8, entries {0,0x01},{1,0x5A} with ready=1 → init 0x38,0x0C,0x06,0x01, then 0x01 (RS=0, long_exec=1), then 0x5A (RS=1); two rd_en pulses.
- i_reinit pulsed during SEND_HI of entry 0x41 with more buffer entries waiting → low nibble 1 still sent; no further pop; o_init_done falls; full init reruns before the next pop.
- i_rst asserted for one cycle mid-init at beat 5 → all outputs return to reset values; the next beat sequence restarts at nibble 2.
